// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type, 3x3 tap offsets and output saturation
// for the cellular-network cell scheduler.
package cnn_pkg;

  localparam int CNN_WIDTH = 9;
  localparam int CNN_YW    = 2 * CNN_WIDTH - 1;
  localparam int NTAPS     = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EVAL,
    WRITE,
    ADV,
    FIN
  } state_t;

  // Row-major neighbourhood offsets: tap 0 is (-1,-1), tap 4 the centre, tap 8 is (+1,+1).
  localparam int DR [NTAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int DC [NTAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  // Output function f(x) = clamp(x, -ymax, +ymax), evaluated on sign-extended values.
  function automatic int sat_y(input int x, input int ymax);
    if (x > ymax) begin
      return ymax;
    end else if (x < -ymax) begin
      return -ymax;
    end
    return x;
  endfunction

endpackage

// File: rtl/cnn_tap_gen.sv
// Maps a cell (row, col) and tap index k to the neighbour address and
// flags neighbours outside the image (fixed zero boundary).
module cnn_tap_gen
  import cnn_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int AW   = $clog2(ROWS * COLS),
  parameter int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
  parameter int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic [RW-1:0] row,
  input  logic [CW-1:0] col,
  input  logic [3:0]    k,
  output logic [AW-1:0] addr,
  output logic          in_bounds
);

  int ki;
  int r;
  int c;

  // NOTE: every output and temporary gets a value before any branch so no latch is inferred.
  always_comb begin
    ki        = (k < 4'd9) ? int'(k) : 4;
    r         = int'(row) + DR[ki];
    c         = int'(col) + DC[ki];
    in_bounds = (k < 4'd9) && (r >= 0) && (r < ROWS) && (c >= 0) && (c < COLS);
    addr      = in_bounds ? AW'(r * COLS + c) : '0;
  end

endmodule

// File: rtl/cnn_cell_sched.sv
// Cell scheduler: sweeps a ROWS x COLS image per iteration, gathers the 3x3
// Y/U neighbourhood into tap registers, saturates the equation result and writes it ping-pong.
module cnn_cell_sched
  import cnn_pkg::*;
#(
  parameter int WIDTH = CNN_WIDTH,
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int YMAX  = 64,
  parameter int AW    = $clog2(ROWS * COLS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [7:0]              iters,
  output logic                    busy,
  output logic                    done,
  output logic                    final_bank,
  output logic                    rd_en,
  output logic [AW-1:0]           rd_addr,
  output logic                    rd_bank,
  input  logic [2*WIDTH-2:0]      rd_y,
  input  logic [WIDTH-1:0]        rd_u,
  output logic [9*(2*WIDTH-1)-1:0] eq_y,
  output logic [9*WIDTH-1:0]      eq_u,
  input  logic [2*WIDTH-2:0]      eq_out,
  output logic                    wr_en,
  output logic [AW-1:0]           wr_addr,
  output logic                    wr_bank,
  output logic [2*WIDTH-2:0]      wr_data
);

  localparam int YW = 2 * WIDTH - 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  state_t state;
  state_t next_state;

  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic          cur_bank;
  logic [7:0]    iter_cnt;
  logic [3:0]    k;
  logic          fin_bank_q;
  logic [YW-1:0] wr_q;

  // Load pipeline: the tap issued on cycle k is written on cycle k+1 when its data returns.
  logic          ld_v;
  logic          ld_inb;
  logic [3:0]    ld_idx;

  logic [NTAPS-1:0][YW-1:0]    ty;
  logic [NTAPS-1:0][WIDTH-1:0] tu;

  logic [AW-1:0] tap_addr;
  logic          tap_inb;
  logic          last_col;
  logic          last_row;
  logic          issuing;

  cnn_tap_gen #(
    .ROWS(ROWS),
    .COLS(COLS),
    .AW  (AW),
    .RW  (RW),
    .CW  (CW)
  ) u_tap_gen (
    .row      (row),
    .col      (col),
    .k        (k),
    .addr     (tap_addr),
    .in_bounds(tap_inb)
  );

  assign last_col = (col == CW'(COLS - 1));
  assign last_row = (row == RW'(ROWS - 1));
  assign issuing  = (state == FETCH) && (k < 4'd9);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = (iters == 8'd0) ? FIN : FETCH;
      FETCH:   if (k == 4'd9) next_state = EVAL;
      EVAL:    next_state = WRITE;
      WRITE:   next_state = ADV;
      ADV: begin
        if (!last_col || !last_row) begin
          next_state = FETCH;
        end else if (iter_cnt == 8'd1) begin
          next_state = FIN;
        end else begin
          next_state = FETCH;
        end
      end
      FIN:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: tap registers drive eq_y/eq_u straight into the equation block, so they are reset too.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row        <= '0;
      col        <= '0;
      cur_bank   <= 1'b0;
      iter_cnt   <= '0;
      k          <= '0;
      fin_bank_q <= 1'b0;
      wr_q       <= '0;
      ld_v       <= 1'b0;
      ld_inb     <= 1'b0;
      ld_idx     <= '0;
      ty         <= '0;
      tu         <= '0;
    end else begin
      ld_v   <= issuing;
      ld_inb <= tap_inb;
      ld_idx <= k;
      if (ld_v) begin
        ty[ld_idx] <= ld_inb ? rd_y : '0;
        tu[ld_idx] <= ld_inb ? rd_u : '0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            iter_cnt <= iters;
            cur_bank <= 1'b0;
            row      <= '0;
            col      <= '0;
            k        <= '0;
            if (iters == 8'd0) fin_bank_q <= 1'b0;
          end
        end
        FETCH: k <= (k == 4'd9) ? 4'd0 : k + 4'd1;
        EVAL:  wr_q <= YW'(sat_y(int'($signed(eq_out)), YMAX));
        ADV: begin
          if (!last_col) begin
            col <= col + 1'b1;
          end else if (!last_row) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            // End of image: the freshly written bank becomes the read bank.
            col      <= '0;
            row      <= '0;
            cur_bank <= ~cur_bank;
            iter_cnt <= iter_cnt - 8'd1;
            if (iter_cnt == 8'd1) fin_bank_q <= ~cur_bank;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy       = (state == FETCH) || (state == EVAL) || (state == WRITE) || (state == ADV);
    done       = (state == FIN);
    final_bank = fin_bank_q;
    rd_en      = issuing && tap_inb;
    rd_addr    = rd_en ? tap_addr : '0;
    rd_bank    = cur_bank;
    wr_en      = (state == WRITE);
    wr_addr    = wr_en ? AW'(int'(row) * COLS + int'(col)) : '0;
    wr_bank    = ~cur_bank;
    wr_data    = wr_q;
  end

  assign eq_y = ty;
  assign eq_u = tu;

endmodule

// File: tb/tb_cnn_cell_sched.sv
// Scoreboard bench for cnn_cell_sched on a 3x3 image: a reference model predicts
// every read, write and done; a negedge monitor compares what the DUT presents.
module tb_cnn_cell_sched;

  localparam int W    = 9;
  localparam int YW   = 2 * W - 1;
  localparam int ROWS = 3;
  localparam int COLS = 3;
  localparam int NC   = ROWS * COLS;
  localparam int AW   = 4;
  localparam int YMAX = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [7:0]      iters = '0;
  logic            busy, done, final_bank;
  logic            rd_en, rd_bank, wr_en, wr_bank;
  logic [AW-1:0]   rd_addr, wr_addr;
  logic [YW-1:0]   rd_y = '0;
  logic [W-1:0]    rd_u = '0;
  logic [9*YW-1:0] eq_y;
  logic [9*W-1:0]  eq_u;
  logic [YW-1:0]   eq_out;
  logic [YW-1:0]   wr_data;

  always #5 clk = ~clk;

  cnn_cell_sched #(
    .WIDTH(W), .ROWS(ROWS), .COLS(COLS), .YMAX(YMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .iters(iters),
    .busy(busy), .done(done), .final_bank(final_bank),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_bank(rd_bank),
    .rd_y(rd_y), .rd_u(rd_u), .eq_y(eq_y), .eq_u(eq_u), .eq_out(eq_out),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .wr_data(wr_data)
  );

  // Environment: initial image, U input and templates for the mock equation block.
  int y_init [NC];
  int u_init [NC];
  int ta [9];
  int tb [9];
  int bias = 0;
  int mode = 0;       // 0: Y5+1, 1: constant, 2: A*Y + B*U + I
  int const_val = 0;
  logic load_mem = 1'b0;

  logic signed [YW-1:0] ymem [2][NC];
  logic signed [W-1:0]  umem [NC];

  always @(posedge clk) begin
    if (load_mem) begin
      for (int i = 0; i < NC; i++) begin
        ymem[0][i] <= YW'(y_init[i]);
        ymem[1][i] <= '0;
        umem[i]    <= W'(u_init[i]);
      end
    end else begin
      if (rd_en) begin
        rd_y <= ymem[rd_bank][rd_addr];
        rd_u <= umem[rd_addr];
      end
      if (wr_en) ymem[wr_bank][wr_addr] <= wr_data;
    end
  end

  int acc;
  always_comb begin
    acc = 0;
    case (mode)
      0: acc = int'($signed(eq_y[4*YW +: YW])) + 1;
      1: acc = const_val;
      default: begin
        acc = bias;
        for (int k = 0; k < 9; k++) begin
          acc = acc + ta[k] * int'($signed(eq_y[k*YW +: YW]))
                    + tb[k] * int'($signed(eq_u[k*W +: W]));
        end
      end
    endcase
    eq_out = acc[YW-1:0];
  end

  typedef struct { bit bank; int addr; } rd_t;
  typedef struct { bit bank; int addr; int data; } wr_t;
  typedef struct { int lat; bit fbank; } dn_t;

  rd_t rd_q [$];
  wr_t wr_q [$];
  dn_t dn_q [$];
  rd_t re;
  wr_t we;
  dn_t de;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the next expected item whenever the DUT presents a read, write or done.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        if (rd_q.size() == 0) begin
          check("unexpected_read", 1, 0);
        end else begin
          re = rd_q.pop_front();
          check("rd_bank", int'(rd_bank), int'(re.bank));
          check("rd_addr", int'(rd_addr), re.addr);
        end
      end
      if (wr_en) begin
        if (wr_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          we = wr_q.pop_front();
          check("wr_bank", int'(wr_bank), int'(we.bank));
          check("wr_addr", int'(wr_addr), we.addr);
          check("wr_data", int'($signed(wr_data)), we.data);
        end
      end
      if (done) begin
        done_cnt++;
        if (dn_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          de = dn_q.pop_front();
          check("done_latency", cyc - start_cyc, de.lat);
          check("final_bank", int'(final_bank), int'(de.fbank));
        end
      end
    end
  end

  function automatic int clamp(input int x);
    if (x > YMAX) return YMAX;
    if (x < -YMAX) return -YMAX;
    return x;
  endfunction

  // Reference model: sweeps the image arithmetically and queues every expected transaction.
  task automatic predict(input int n);
    int img [2][NC];
    int b;
    int rr, cc, v;
    for (int i = 0; i < NC; i++) begin
      img[0][i] = y_init[i];
      img[1][i] = 0;
    end
    b = 0;
    for (int it = 0; it < n; it++) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          v = bias;
          for (int k = 0; k < 9; k++) begin
            rr = r + k / 3 - 1;
            cc = c + k % 3 - 1;
            if (rr >= 0 && rr < ROWS && cc >= 0 && cc < COLS) begin
              rd_q.push_back('{bank: b[0], addr: rr * COLS + cc});
              v += ta[k] * img[b][rr*COLS+cc] + tb[k] * u_init[rr*COLS+cc];
            end
          end
          if (mode == 0) v = img[b][r*COLS+c] + 1;
          if (mode == 1) v = const_val;
          v = clamp(v);
          img[1-b][r*COLS+c] = v;
          wr_q.push_back('{bank: ~b[0], addr: r * COLS + c, data: v});
        end
      end
      b = 1 - b;
    end
    dn_q.push_back('{lat: 1 + 13 * NC * n, fbank: b[0]});
  endtask

  task automatic load(input bit zero);
    for (int i = 0; i < NC; i++) begin
      y_init[i] = zero ? 0 : int'($urandom_range(0, 200)) - 100;
      u_init[i] = int'($urandom_range(0, 200)) - 100;
    end
    load_mem = 1'b1;
    @(posedge clk); #1;
    load_mem = 1'b0;
  endtask

  task automatic check_taps();
    int rr, cc, ey, eu;
    for (int k = 0; k < 9; k++) begin
      rr = k / 3 - 1;
      cc = k % 3 - 1;
      ey = 0;
      eu = 0;
      if (rr >= 0 && cc >= 0) begin
        ey = y_init[rr*COLS+cc];
        eu = u_init[rr*COLS+cc];
      end
      check($sformatf("tap_y%0d", k), int'($signed(eq_y[k*YW +: YW])), ey);
      check($sformatf("tap_u%0d", k), int'($signed(eq_u[k*W +: W])), eu);
    end
  endtask

  task automatic run(input int n, input bit pokes, input bit tapchk);
    int budget, t, target;
    predict(n);
    target = done_cnt + 1;
    budget = 13 * NC * n + 20;
    start = 1'b1;
    iters = 8'(n);
    start_cyc = cyc;
    t = 0;
    while (done_cnt < target && t < budget) begin
      @(posedge clk); #1;
      t++;
      start = 1'b0;
      if (pokes && busy && (t % 37 == 5)) begin
        start = 1'b1;
        iters = 8'($urandom_range(0, 255));
      end
      if (tapchk && cyc == start_cyc + 11) check_taps();
    end
    start = 1'b0;
    if (done_cnt < target) check("done_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
    check("rd_queue_drained", rd_q.size(), 0);
    check("wr_queue_drained", wr_q.size(), 0);
    check("busy_after_done", int'(busy), 0);
    rd_q.delete();
    wr_q.delete();
    dn_q.delete();
  endtask

  task automatic rand_templates();
    for (int k = 0; k < 9; k++) begin
      ta[k] = int'($urandom_range(0, 6)) - 3;
      tb[k] = int'($urandom_range(0, 6)) - 3;
    end
    bias = int'($urandom_range(0, 100)) - 50;
  endtask

  initial begin
    for (int k = 0; k < 9; k++) begin
      ta[k] = 0;
      tb[k] = 0;
    end

    // Reset with start toggling: nothing may leave IDLE.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      start = (i != 1);
      iters = 8'd5;
    end
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_rd_en", int'(rd_en), 0);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_eq_y_zero", int'(eq_y == '0), 1);
    check("rst_final_bank", int'(final_bank), 0);
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_after_rst", int'(busy), 0);

    // Ping-pong with Y5+1 on a zero image: 1s into bank1, then 2s into bank0.
    load(1'b1);
    mode = 0;
    run(2, 1'b0, 1'b1);

    // Saturation of the equation output.
    mode = 1;
    const_val = 100;
    run(1, 1'b0, 1'b0);
    const_val = -100;
    run(1, 1'b0, 1'b0);
    const_val = 64;
    run(1, 1'b0, 1'b0);

    // Zero iterations: immediate done, no memory traffic.
    run(0, 1'b0, 1'b0);

    // Random images and templates, with start pulses while busy.
    mode = 2;
    for (int r = 0; r < 4; r++) begin
      load(1'b0);
      rand_templates();
      run(r % 3 + 1, r[0], 1'b1);
    end

    // Reset during FETCH of cell 4, then a full sweep.
    load(1'b0);
    rand_templates();
    predict(1);
    start = 1'b1;
    iters = 8'd1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < start_cyc + 1 + 13 * 4 + 3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_rd_en", int'(rd_en), 0);
    check("midrst_wr_en", int'(wr_en), 0);
    rd_q.delete();
    wr_q.delete();
    dn_q.delete();
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("midrst_stays_idle", int'(busy), 0);
    load(1'b0);
    run(2, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_cell_sched.md
Name: cnn_cell_sched

Overview:
- Sequencer for the cellular-network state-update datapath (Xnew = A*Y + B*U + I).
- Walks every cell of a ROWS x COLS image for a programmed number of iterations.
- For each cell it fetches the 3x3 Y and U neighbourhoods into operand registers that feed the combinational equation block.
- It then saturates the result and writes it to a ping-pong Y memory, so one full image is updated per iteration.

Parameters:
- WIDTH, 9, signed template/input width; Y/state width YW = 2*WIDTH-1 (17).
- ROWS, 8, image rows (>=1).
- COLS, 8, image columns (>=1).
- YMAX, 64, saturation magnitude applied to the equation output (output function f(x)=clamp(x,-YMAX,+YMAX)).
- AW, $clog2(ROWS*COLS), cell address width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- iters  in  8  iteration count, sampled on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at completion.
- final_bank  out  1  Y bank holding the final result; valid with done, held until the next start.
- rd_en  out  1  memory read strobe.
- rd_addr  out  AW  cell address = row*COLS+col.
- rd_bank  out  1  Y bank to read.
- rd_y  in  YW  Y data, valid the cycle after rd_en.
- rd_u  in  WIDTH  U data, valid the cycle after rd_en.
- eq_y  out  9*YW  tap registers Y1..Y9, Y1 in LSBs.
- eq_u  out  9*WIDTH  tap registers U1..U9, U1 in LSBs.
- eq_out  in  YW  combinational equation result for the current eq_y/eq_u.
- wr_en  out  1  write strobe.
- wr_addr  out  AW  write address.
- wr_bank  out  1  write bank, always the opposite of rd_bank.
- wr_data  out  YW  saturated new Y.

Behaviour:
- Reset (rst_n=0 at a clock edge): state IDLE; busy, done, rd_en, wr_en, final_bank = 0; all address, bank, tap and data registers = 0.
- Reset mid-operation abandons the sweep with no further writes.
- Tap order k=0..8 is row-major over offsets (dr,dc), dr,dc ∈ {-1,0,+1}: k=0 is (-1,-1), k=4 is the centre, k=8 is (+1,+1).
- Boundary taps: when row+dr or col+dc falls outside the image, the tap issues no read (rd_en=0) and loads zero into both its Y and U registers (fixed zero boundary).
- FSM states:
  - IDLE: on start, latch iters, cur_bank=0, row=col=0, busy=1. If iters=0, go to FIN; otherwise go to FETCH.
  - FETCH: 9 issue cycles (k=0..8), then 1 drain cycle. Returned data, or zero for boundary taps, is written to tap k-1 on the cycle after issue, using a 1-cycle valid/index pipeline.
  - EVAL: 1 cycle. Register r = eq_out, then saturate: wr_data = (r>YMAX)?YMAX : (r<-YMAX)?-YMAX : r.
  - WRITE: 1 cycle. wr_en=1, wr_addr = centre address, wr_bank = ~cur_bank.
  - ADV: if col<COLS-1, col++ and go to FETCH. Else if row<ROWS-1, col=0, row++ and go to FETCH. Otherwise flip cur_bank and decrement the iteration count: if it reaches 0 go to FIN, else reset row=col=0 and go to FETCH.
  - FIN: done=1 for one cycle, busy=0, final_bank=cur_bank, go to IDLE.
- Cell cost: exactly 13 cycles (9+1+1+1+1). Total latency from start to done for iters>0 = 1 + 13*ROWS*COLS*iters cycles.
- rd_bank = cur_bank throughout an iteration. Reads never touch the bank being written within the same iteration.
- start while busy is ignored. start coincident with FIN is ignored; a new start is accepted in IDLE on the next cycle.
- ROWS=1 or COLS=1: every out-of-range neighbour takes the zero path. No other special case.
- Arithmetic: all comparisons signed, YMAX sign-extended to YW.

Decomposition:
- Package cnn_pkg:
  - WIDTH and YW constants.
  - State enum {IDLE, FETCH, EVAL, WRITE, ADV, FIN}.
  - Tap offset constant arrays DR[9] and DC[9].
  - Function sat_y(x, ymax).
- Sub-module cnn_tap_gen (combinational): inputs row, col, k; outputs tap address and in_bounds flag.

Test Plan:
- Reset values: hold rst_n=0 for 3 cycles, pulsing start -> busy=0, done=0, rd_en=0, wr_en=0, eq_y=0; no state change.
- Corner tap masking: ROWS=COLS=3, iters=1, cell (0,0) -> exactly 4 reads at addresses {0,1,3,4}; taps k=0,1,2,3,6 load zero.
- Ping-pong banks: ROWS=COLS=3, iters=2, mock eq_out = Y5+1, bank0 all 0 -> iter1 writes 1 to all 9 cells of bank1, iter2 writes 2 to bank0; final_bank=0; done exactly 1+13*9*2=235 cycles after start.
- Saturation: eq_out = +100, then -100, then +64 with YMAX=64 -> wr_data = 64, -64, 64.
- Zero iterations and start while busy: iters=0 -> done 1 cycle after start, no rd_en/wr_en, final_bank=0. Start pulsed during busy -> no effect on the count, address sequence or done timing.
- Reset mid-operation: rst_n=0 during FETCH of cell 4 -> next cycle IDLE, busy=0, no wr_en. A subsequent start runs a full, correct sweep.
